fpdiv_ctrl: RTL and testbench

- Moore FSM that sequences the 32-bit Goldschmidt fpdiv datapath. It drives the register enables (en_a, en_b, en_rem) and the multiplier operand selects (sel_mux3, sel_mux4) through initial scaling, ITERS refinement iterations and the remainder multiply.
- It presents a start/busy/done/result_valid handshake to the issuing unit.
- It sits beside fpdiv in the FPU top; its outputs connect one-to-one to the fpdiv ports of the same names.

---
 rtl/fpdiv_pkg.sv | 26 ++
 rtl/fpdiv_ctrl.sv | 116 +++++++++++
 tb/tb_fpdiv_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and operand-select codes for the Goldschmidt divider controller.
// The enum is also the state register encoding.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    N0   = 3'd1,
    D0   = 3'd2,
    ITN  = 3'd3,
    ITD  = 3'd4,
    REM  = 3'd5,
    DONE = 3'd6
  } state_t;

  // Multiplier operand A selects
  localparam logic [1:0] SEL3_IA  = 2'd0;
  localparam logic [1:0] SEL3_OC  = 2'd1;
  localparam logic [1:0] SEL3_DEN = 2'd2;

  // Multiplier operand B selects
  localparam logic [1:0] SEL4_NUM = 2'd0;
  localparam logic [1:0] SEL4_DEN = 2'd1;
  localparam logic [1:0] SEL4_RA  = 2'd2;
  localparam logic [1:0] SEL4_RB  = 2'd3;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for the Goldschmidt fpdiv datapath: initial scaling, ITERS
// refinement passes, then the remainder multiply, behind a start/done handshake.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          en_a,
  output logic          en_b,
  output logic          en_rem,
  output logic [1:0]    sel_mux3,
  output logic [1:0]    sel_mux4,
  output logic          busy,
  output logic          done,
  output logic          result_valid,
  output logic [CW-1:0] iter_cnt
);

  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  state_t state;
  state_t next_state;
  logic   accept;
  logic   more_iters;

  // A new divide is only taken when the datapath is free (IDLE or DONE).
  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign more_iters = (iter_cnt < LAST_ITER);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    next_state = start ? N0 : IDLE;
      N0:      next_state = D0;
      D0:      next_state = ITN;
      ITN:     next_state = ITD;
      ITD:     next_state = more_iters ? ITN : REM;
      REM:     next_state = DONE;
      DONE:    next_state = start ? N0 : IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // ITD must follow ITN: en_b rewrites regc, which ITN still needs as operand.
  always_comb begin
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_rem   = 1'b0;
    sel_mux3 = SEL3_IA;
    sel_mux4 = SEL4_NUM;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: ;
      N0: begin
        sel_mux3 = SEL3_IA;
        sel_mux4 = SEL4_NUM;
        en_a     = 1'b1;
        busy     = 1'b1;
      end
      D0: begin
        sel_mux3 = SEL3_IA;
        sel_mux4 = SEL4_DEN;
        en_b     = 1'b1;
        busy     = 1'b1;
      end
      ITN: begin
        sel_mux3 = SEL3_OC;
        sel_mux4 = SEL4_RA;
        en_a     = 1'b1;
        busy     = 1'b1;
      end
      ITD: begin
        sel_mux3 = SEL3_OC;
        sel_mux4 = SEL4_RB;
        en_b     = 1'b1;
        busy     = 1'b1;
      end
      REM: begin
        sel_mux3 = SEL3_DEN;
        sel_mux4 = SEL4_RA;
        en_rem   = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                iter_cnt <= '0;
    else if (abort)                           iter_cnt <= '0;
    else if (accept)                          iter_cnt <= '0;
    else if ((state == ITD) && more_iters)    iter_cnt <= iter_cnt + CW'(1);
  end

  // result_valid survives the return to IDLE so the issuer can read it late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               result_valid <= 1'b0;
    else if (abort)          result_valid <= 1'b0;
    else if (accept)         result_valid <= 1'b0;
    else if (state == REM)   result_valid <= 1'b1;
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Randomised and directed bench for fpdiv_ctrl; runs ITERS=3 and ITERS=1 copies
// side by side against a cycle-position model of the divide sequence.
module tb_fpdiv_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic abort;

  logic          en_a_d   [2];
  logic          en_b_d   [2];
  logic          en_rem_d [2];
  logic [1:0]    sel3_d   [2];
  logic [1:0]    sel4_d   [2];
  logic          busy_d   [2];
  logic          done_d   [2];
  logic          rv_d     [2];
  logic [CW-1:0] it_d     [2];

  int iters_of [2] = '{3, 1};
  int pos      [2];
  int rv_m     [2];
  int it_m     [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITERS(3), .CW(CW)) dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .en_a(en_a_d[0]), .en_b(en_b_d[0]), .en_rem(en_rem_d[0]),
    .sel_mux3(sel3_d[0]), .sel_mux4(sel4_d[0]),
    .busy(busy_d[0]), .done(done_d[0]), .result_valid(rv_d[0]),
    .iter_cnt(it_d[0])
  );

  fpdiv_ctrl #(.ITERS(1), .CW(CW)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .en_a(en_a_d[1]), .en_b(en_b_d[1]), .en_rem(en_rem_d[1]),
    .sel_mux3(sel3_d[1]), .sel_mux4(sel4_d[1]),
    .busy(busy_d[1]), .done(done_d[1]), .result_valid(rv_d[1]),
    .iter_cnt(it_d[1])
  );

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h at %0t", tag, k, obs, exp, $time);
    end
  endtask

  // pos is the cycle index since the accepting edge: 1=N0, 2=D0, then ITN/ITD pairs,
  // then REM and DONE at 4+2*ITERS; 0 means idle.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; rv_m[k] = 0; it_m[k] = 0;
    end
  endtask

  task automatic model_edge(input logic s, input logic a);
    for (int k = 0; k < 2; k++) begin
      int last;
      last = 4 + 2 * iters_of[k];
      if (a) begin
        pos[k] = 0; rv_m[k] = 0; it_m[k] = 0;
      end else if ((pos[k] == 0 || pos[k] == last) && s) begin
        pos[k] = 1; rv_m[k] = 0; it_m[k] = 0;
      end else if (pos[k] == last) begin
        pos[k] = 0;
      end else if (pos[k] > 0) begin
        pos[k] = pos[k] + 1;
        if (pos[k] == last) rv_m[k] = 1;
        if (pos[k] >= 3 && pos[k] <= 2 + 2 * iters_of[k]) it_m[k] = (pos[k] - 3) / 2;
      end
    end
  endtask

  task automatic check_output();
    for (int k = 0; k < 2; k++) begin
      int p, last, ea, eb, er, s3, s4;
      bit in_it, is_itn;
      p      = pos[k];
      last   = 4 + 2 * iters_of[k];
      in_it  = (p >= 3) && (p <= 2 + 2 * iters_of[k]);
      is_itn = in_it && (((p - 3) % 2) == 0);
      ea = (p == 1 || is_itn) ? 1 : 0;
      eb = (p == 2 || (in_it && !is_itn)) ? 1 : 0;
      er = (p == last - 1) ? 1 : 0;
      s3 = in_it ? 1 : (p == last - 1) ? 2 : 0;
      s4 = (p == 2) ? 1 : is_itn ? 2 : in_it ? 3 : (p == last - 1) ? 2 : 0;
      check("en_a",         k, 32'(en_a_d[k]),   32'(ea));
      check("en_b",         k, 32'(en_b_d[k]),   32'(eb));
      check("en_rem",       k, 32'(en_rem_d[k]), 32'(er));
      check("sel_mux3",     k, 32'(sel3_d[k]),   32'(s3));
      check("sel_mux4",     k, 32'(sel4_d[k]),   32'(s4));
      check("busy",         k, 32'(busy_d[k]),   32'((p >= 1 && p < last) ? 1 : 0));
      check("done",         k, 32'(done_d[k]),   32'((p == last) ? 1 : 0));
      check("result_valid", k, 32'(rv_d[k]),     32'(rv_m[k]));
      check("iter_cnt",     k, 32'(it_d[k]),     32'(it_m[k]));
      check("enables_onehot0", k,
            32'(($countones({en_a_d[k], en_b_d[k], en_rem_d[k]}) <= 1) ? 1 : 0), 32'd1);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic a);
    start = s;
    abort = a;
    model_edge(s, a);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    model_reset();
    #12;
    check_output();
    reset = 1'b0;

    $display("[TB] single divide");
    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 11; i++) apply_stimulus(1'b0, 1'b0);

    $display("[TB] start held high");
    for (int i = 0; i < 25; i++) apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0);

    $display("[TB] abort during iteration");
    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0);

    $display("[TB] abort and start together in IDLE");
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0);

    $display("[TB] asynchronous reset during REM");
    apply_stimulus(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_output();
    @(posedge clk);
    #1;
    check_output();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0);

    $display("[TB] random start/abort traffic");
    for (int i = 0; i < 400; i++) begin
      logic rs, ra;
      rs = ($urandom_range(0, 1) == 1);
      ra = ($urandom_range(0, 15) == 0);
      apply_stimulus(rs, ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
